effect_scheduler: RTL and testbench

Frame-synchronous controller for the pixel filter chain (threshold, brightness, blur, ADSR, 3x3 edge kernel). It debounces a mode pushbutton, optionally auto-advances the mode every N detected beats, and holds the new mode as pending. Each change is committed only at a frame boundary, so enables never change mid-frame (no tearing). It sits in the pix_clk domain between the button/beat sources and the filter enable inputs.

---
 rtl/effect_pkg.sv | 41 ++++
 rtl/effect_scheduler_key_debounce.sv | 54 +++++
 rtl/effect_scheduler.sv | 118 +++++++++++
 tb/tb_effect_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/effect_pkg.sv
// Shared types for the effect scheduler: mode encoding, filter-enable bundle
// and the mode-to-enable decode table.
package effect_pkg;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_THRESH,
    MODE_SOFT,
    MODE_EDGE
  } mode_t;

  // 'edge' is a reserved word, so the Sobel-select field is edge_sel
  typedef struct packed {
    logic thresh;
    logic bright;
    logic blur;
    logic adsr;
    logic edge_sel;
  } fx_enables_t;

  localparam fx_enables_t FX_NONE = '0;

  function automatic fx_enables_t decode_mode(input mode_t m);
    fx_enables_t en;
    en = FX_NONE;
    case (m)
      MODE_THRESH: en.thresh = 1'b1;
      MODE_SOFT: begin
        en.bright = 1'b1;
        en.blur   = 1'b1;
      end
      MODE_EDGE: begin
        en.adsr     = 1'b1;
        en.edge_sel = 1'b1;
      end
      default: en = FX_NONE;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/effect_scheduler_key_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low pushbutton;
// emits a one-cycle pulse when a press (1->0 of the accepted level) is accepted.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter measures how long the synced key has disagreed with the
  // accepted level; any return to agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/effect_scheduler.sv
// Frame-synchronous mode controller: collects button presses and beat-driven
// advances as a pending mode and commits it only on frame_start.
module effect_scheduler
  import effect_pkg::*;
#(
  parameter int NUM_MODES       = 4,
  parameter int BEATS_PER_MODE  = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_key_n,
  input  logic       auto_en,
  input  logic       beat_in,
  input  logic       frame_start,
  output logic       thresh_en,
  output logic       bright_en,
  output logic       blur_en,
  output logic       adsr_en,
  output logic       edge_en,
  output logic [1:0] mode,
  output logic       pending,
  output logic       mode_changed
);

  localparam int BC_W = (BEATS_PER_MODE > 1) ? $clog2(BEATS_PER_MODE) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEATS_PER_MODE - 1);

  function automatic mode_t next_mode(input mode_t m);
    if (int'(m) >= NUM_MODES - 1) return MODE_PASS;
    return mode_t'(m + 2'd1);
  endfunction

  logic            press_evt;
  logic            beat_sync1_q, beat_sync2_q, beat_prev_q;
  logic            beat_evt, adv_evt, req, commit;
  logic [BC_W-1:0] beat_count_q, beat_count_d;
  mode_t           mode_q, mode_d, pending_mode_q, pending_mode_d, base_mode;
  logic            pending_q, pending_d;
  logic            changed_q, changed_d;
  fx_enables_t     en_q, en_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_key (
    .clk    (clk),
    .reset  (reset),
    .key_n_i(mode_key_n),
    .press_o(press_evt)
  );

  assign beat_evt = beat_sync2_q & ~beat_prev_q;
  assign adv_evt  = auto_en & beat_evt & (beat_count_q == BC_LAST);
  assign req      = press_evt | adv_evt;
  assign commit   = frame_start & pending_q;

  always_comb begin
    beat_count_d = beat_count_q;
    if (press_evt || adv_evt) begin
      beat_count_d = '0;
    end else if (auto_en && beat_evt) begin
      beat_count_d = beat_count_q + 1'b1;
    end
  end

  // When a commit and a request coincide, the committed mode equals
  // pending_mode_q, so the same base serves both cases.
  always_comb begin
    base_mode      = pending_q ? pending_mode_q : mode_q;
    mode_d         = mode_q;
    en_d           = en_q;
    pending_d      = pending_q & ~commit;
    pending_mode_d = pending_mode_q;
    changed_d      = commit;
    if (commit) begin
      mode_d = pending_mode_q;
      en_d   = decode_mode(pending_mode_q);
    end
    if (req) begin
      pending_d      = 1'b1;
      pending_mode_d = next_mode(base_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_sync1_q   <= 1'b0;
      beat_sync2_q   <= 1'b0;
      beat_prev_q    <= 1'b0;
      beat_count_q   <= '0;
      mode_q         <= MODE_PASS;
      pending_mode_q <= MODE_PASS;
      pending_q      <= 1'b0;
      changed_q      <= 1'b0;
      en_q           <= FX_NONE;
    end else begin
      beat_sync1_q   <= beat_in;
      beat_sync2_q   <= beat_sync1_q;
      beat_prev_q    <= beat_sync2_q;
      beat_count_q   <= beat_count_d;
      mode_q         <= mode_d;
      pending_mode_q <= pending_mode_d;
      pending_q      <= pending_d;
      changed_q      <= changed_d;
      en_q           <= en_d;
    end
  end

  assign thresh_en    = en_q.thresh;
  assign bright_en    = en_q.bright;
  assign blur_en      = en_q.blur;
  assign adsr_en      = en_q.adsr;
  assign edge_en      = en_q.edge_sel;
  assign mode         = mode_q;
  assign pending      = pending_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_effect_scheduler.sv
// Randomized and directed bench for effect_scheduler against a cycle-level
// behavioural model of debounce, beat counting and frame-synchronous commit.
module tb_effect_scheduler;

  localparam int NM  = 4;
  localparam int BPM = 3;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic       beat_in = 1'b0;
  logic       frame_start = 1'b0;
  logic       thresh_en, bright_en, blur_en, adsr_en, edge_en;
  logic [1:0] mode;
  logic       pending, mode_changed;

  effect_scheduler #(
    .NUM_MODES      (NM),
    .BEATS_PER_MODE (BPM),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_key_n  (mode_key_n),
    .auto_en     (auto_en),
    .beat_in     (beat_in),
    .frame_start (frame_start),
    .thresh_en   (thresh_en),
    .bright_en   (bright_en),
    .blur_en     (blur_en),
    .adsr_en     (adsr_en),
    .edge_en     (edge_en),
    .mode        (mode),
    .pending     (pending),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (values after the most recent clock edge)
  int m_mode, m_pmode, m_pend, m_chg, m_bcnt, m_acc, m_run, m_press;
  bit kh[3];
  bit bh[3];
  int cyc = 0;
  int fp = 50;

  function automatic logic [4:0] exp_en(input int md);
    case (md)
      1:       return 5'b10000;
      2:       return 5'b01100;
      3:       return 5'b00011;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_edge();
    bit ks, bevt, press_now, adv;
    if (!reset) begin
      m_mode = 0; m_pmode = 0; m_pend = 0; m_chg = 0; m_bcnt = 0;
      m_acc = 1; m_run = 0; m_press = 0;
      kh[0] = 1; kh[1] = 1; kh[2] = 1;
      bh[0] = 0; bh[1] = 0; bh[2] = 0;
      return;
    end
    // key and beat are seen two edges late through the synchronizers
    ks        = kh[1];
    bevt      = bh[1] && !bh[2];
    press_now = m_press[0];
    m_press   = 0;
    if (ks != m_acc[0]) begin
      m_run++;
      if (m_run == DEB) begin
        m_acc   = ks;
        m_run   = 0;
        m_press = (ks == 1'b0);
      end
    end else begin
      m_run = 0;
    end
    adv = auto_en && bevt && (m_bcnt == BPM - 1);
    if (press_now || adv) m_bcnt = 0;
    else if (auto_en && bevt) m_bcnt = m_bcnt + 1;
    m_chg = (frame_start && m_pend != 0) ? 1 : 0;
    if (m_chg != 0) begin
      m_mode = m_pmode;
      m_pend = 0;
    end
    if (press_now || adv) begin
      m_pmode = (((m_pend != 0) ? m_pmode : m_mode) + 1) % NM;
      m_pend  = 1;
    end
    kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = mode_key_n;
    bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = beat_in;
  endtask

  task automatic tick(input bit key, input bit beat, input bit autoe, input bit fs, input bit rst);
    mode_key_n  = key;
    beat_in     = beat;
    auto_en     = autoe;
    frame_start = fs;
    reset       = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("pending", 32'(pending), 32'(m_pend));
    check_eq("mode_changed", 32'(mode_changed), 32'(m_chg));
    check_eq("enables", 32'({thresh_en, bright_en, blur_en, adsr_en, edge_en}), 32'(exp_en(m_mode)));
    if (m_chg != 0) $display("commit t=%0t mode=%0d pending=%0d", $time, m_mode, m_pend);
    cyc++;
  endtask

  task automatic step(input bit key, input bit beat, input bit autoe);
    tick(key, beat, autoe, (cyc % fp) == fp - 1, 1'b1);
  endtask

  task automatic to_frame(input bit autoe);
    do step(1'b1, 1'b0, autoe); while ((cyc % fp) != 0);
  endtask

  task automatic press(input bit autoe);
    repeat (8) step(1'b0, 1'b0, autoe);
    repeat (8) step(1'b1, 1'b0, autoe);
  endtask

  initial begin
    bit klev, blev, aut;
    int khold, bhold;

    // 1: reset then idle frames
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc = 0; fp = 50;
    repeat (100) step(1'b1, 1'b0, 1'b0);

    // 2: bounces then a held press, committed at the frame boundary
    for (int i = 0; i < 60; i++)
      step(!(i == 3 || i == 6 || (i >= 10 && i < 20)), 1'b0, 1'b0);
    to_frame(1'b0);

    // 3: three presses in one frame, then four presses (wrap)
    cyc = 0; fp = 100;
    repeat (3) press(1'b0);
    to_frame(1'b0);
    repeat (4) press(1'b0);
    to_frame(1'b0);

    // 4: beat-driven advance, then beats ignored with auto_en low
    cyc = 0; fp = 1000;
    for (int b = 0; b < 7; b++) begin
      repeat (5) step(1'b1, 1'b1, 1'b1);
      repeat (5) step(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    for (int b = 0; b < 3; b++) begin
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // 5a: a press landing on the same cycle as the wrapping beat
    repeat (5) step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      step(!(i < 8), (i >= 4 && i < 9), 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // 5b: one press pending, then a press coincident with frame_start
    press(1'b0);
    for (int i = 0; i < 12; i++) tick(!(i < 8), 1'b0, 1'b0, i == 6, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // 6: reset mid-frame discards the pending change
    press(1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Randomized traffic
    klev = 1; blev = 0; aut = 1; khold = 0; bhold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (khold == 0) begin klev = 1'($urandom_range(0, 1)); khold = $urandom_range(1, 12); end
      if (bhold == 0) begin blev = 1'($urandom_range(0, 1)); bhold = $urandom_range(1, 8); end
      khold--; bhold--;
      if ($urandom_range(0, 199) == 0) aut = !aut;
      tick(klev, blev, aut, $urandom_range(0, 29) == 0, $urandom_range(0, 699) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
